aes128_decrypt_core: RTL and testbench
======================================

Name: aes128_decrypt_core

Overview:
- Iterative AES-128 decryption engine: the inverse counterpart of the encryption round datapath.
- Takes a 128-bit ciphertext and the round-10 (final) expanded key.
- Derives round keys 9..0 backward on the fly, one round per clock.
- Returns the plaintext with a single-cycle valid pulse; it sits beside the encryption path in the AES_128 design.

Parameters:
- None. AES-128 is fixed: Nk=4, Nr=10.

Ports:
- i_clk  input  1  rising-edge clock
- i_rst  input  1  synchronous, active-high reset
- i_start  input  1  request; accepted only when o_ready=1
- i_cipherText  input  128  ciphertext block, FIPS-197 byte order
- i_decKey  input  128  round-10 round key, FIPS-197 byte order
- o_ready  output  1  core idle, can accept i_start
- o_busy  output  1  decryption in progress (equals ~o_ready)
- o_valid  output  1  one-cycle pulse: o_plainText updated
- o_plainText  output  128  result; held until the next completion

Behaviour:
- Clocking and reset: one clock, reset is synchronous and active-high.
- Byte mapping: state byte(r,c) = bits [127-8*(4c+r) -: 8], column-major per FIPS-197. Byte 0 is the MSB.
- Reset values: FSM=IDLE, o_ready=1, o_busy=0, o_valid=0, o_plainText=0, internal state/key registers=0, round counter=0.
- FSM states: IDLE, ROUND.
- IDLE: on i_start=1 at edge T:
  - state <= i_cipherText ^ i_decKey
  - rk <= i_decKey
  - rnd <= 9
  - go to ROUND
- ROUND, each cycle:
  - Derive K_rnd combinationally from rk = K_(rnd+1) = (a0,a1,a2,a3), 32-bit words:
    - b3=a3^a2
    - b2=a2^a1
    - b1=a1^a0
    - b0=a0^SubWord(RotWord(b3))^{Rcon[rnd+1],24'h0}
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
  - Round output: t = InvSubBytes(InvShiftRows(state)) ^ K_rnd. If rnd!=0, then state <= InvMixColumns(t); if rnd==0, state <= t.
  - rk <= K_rnd.
  - rnd 9..1: rnd <= rnd-1, stay in ROUND.
  - rnd==0: o_plainText <= t, o_valid <= 1, FSM <= IDLE.
- Latency: start accepted at edge T gives o_valid=1 for exactly the cycle after edge T+10. Throughput is one block per 11 cycles.
- o_ready=1 during the o_valid cycle. A start in that cycle is accepted, giving back-to-back operation with no bubble.
- i_start while busy is ignored: no queuing, and the in-flight operation is unaffected.
- i_cipherText and i_decKey are sampled only at the accepting edge; later changes have no effect.
- Reset mid-operation aborts immediately:
  - all reset values apply
  - no o_valid is produced for the aborted block
  - o_plainText returns to 0
- Reset takes priority over i_start in the same cycle.
- Arithmetic:
  - GF(2^8) with polynomial 0x11b.
  - InvMixColumns matrix rows: {0e,0b,0d,09} rotated.
  - All operations are width-preserving 8-bit XOR/multiply; no carries.
- Critical path (one round + key step per cycle) is acceptable. No pipelining inside a round.

Decomposition:
- Shared package aes_pkg:
  - forward S-box and inverse S-box functions (256-entry tables)
  - Rcon table
  - xtime and gf_mul functions
  - byte(r,c) index helper
  - FSM state enum
- One natural sub-module: decryption_round (combinational).
  - Inputs: 128-bit state, 128-bit round key, i_lastRound.
  - Performs InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless i_lastRound=1.
  - The key-backstep logic stays in the core.

Test Plan:
- Reset: hold i_rst 3 cycles -> o_ready=1, o_busy=0, o_valid=0, o_plainText=0.
- FIPS-197 C.1: i_cipherText=69c4e0d86a7b0430d8cdb78070b4c55a, i_decKey=13111d7fe3944a17f307a78b4d2b30c5, start at edge T -> o_valid high only in the cycle after edge T+10, o_plainText=00112233445566778899aabbccddeeff, o_busy=1 for edges T+1..T+10.
- FIPS-197 App. B: i_cipherText=3925841d02dc09fbdc118597196a0b32, i_decKey=d014f9a8c9ee2589e13f0cc8b6630ca6 -> o_plainText=3243f6a8885a308d313198a2e0370734.
- Zero key (round-10 key b4ef5bcb3e92e21123e951cf6f8f188e), ciphertext 66e94bd4ef8a2c3b884cfa59ca342b2e, then start the App. B block in the o_valid cycle -> first result 000…0, second result valid exactly 11 cycles later, no bubble.
- Protocol corners:
  - Pulse i_start with new data at T+4 of a running job -> ignored, C.1 result unchanged.
  - Assert i_rst at T+6 -> no o_valid, o_ready=1 the next cycle.
  - Restart after the reset -> correct C.1 result.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: S-box tables, Rcon, GF(2^8) helpers and the
// decryption FSM state type.
package aes_pkg;

   typedef enum logic {
      IDLE,
      ROUND
   } decState_t;

   localparam logic [0:255][7:0] SBOX = {
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [0:255][7:0] INV_SBOX = {
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   // Rcon[1..10]; the unused slots keep any 4-bit index in range.
   localparam logic [0:15][7:0] RCON = {
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
      8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   localparam logic [0:3][7:0] INV_MIX = {8'h0e, 8'h0b, 8'h0d, 8'h09};

   function automatic logic [7:0] sBox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   function automatic logic [7:0] invSBox(input logic [7:0] b);
      return INV_SBOX[b];
   endfunction

   function automatic logic [31:0] subWord(input logic [31:0] w);
      return {sBox(w[31:24]), sBox(w[23:16]), sBox(w[15:8]), sBox(w[7:0])};
   endfunction

   function automatic logic [7:0] xTime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = xTime(sh);
      end
      return acc;
   endfunction

   // MSB position of state byte (r,c) within a 128-bit block; byte 0 is the MSB.
   function automatic int byteMsb(input int r, input int c);
      return 127 - 8 * (4 * c + r);
   endfunction

endpackage

// File: rtl/decryption_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns except on the last round.
module decryption_round
   import aes_pkg::*;
(
   input  logic [127:0] i_state,
   input  logic [127:0] i_roundKey,
   input  logic         i_lastRound,
   output logic [127:0] o_state
);

   function automatic logic [31:0] invMixColumn(input logic [31:0] col);
      logic [31:0] res;
      res = '0;
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 4; k++)
            res[31-8*r -: 8] = res[31-8*r -: 8] ^ gfMul(col[31-8*k -: 8], INV_MIX[2'(k - r)]);
      return res;
   endfunction

   logic [127:0] shifted;
   logic [127:0] keyed;
   logic [127:0] mixed;

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      shifted = '0;
      mixed   = '0;
      // Row r rotates right by r columns.
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            shifted[byteMsb(r, c) -: 8] = invSBox(i_state[byteMsb(r, (c - r + 4) % 4) -: 8]);
      keyed = shifted ^ i_roundKey;
      for (int c = 0; c < 4; c++)
         mixed[127-32*c -: 32] = invMixColumn(keyed[127-32*c -: 32]);
      o_state = i_lastRound ? keyed : mixed;
   end

endmodule

// File: rtl/aes128_decrypt_core.sv
// Iterative AES-128 decryption: one inverse round per clock, round keys derived
// backwards from the round-10 key as the rounds proceed.
module aes128_decrypt_core
   import aes_pkg::*;
(
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_start,
   input  logic [127:0] i_cipherText,
   input  logic [127:0] i_decKey,
   output logic         o_ready,
   output logic         o_busy,
   output logic         o_valid,
   output logic [127:0] o_plainText
);

   decState_t    fsm;
   logic [127:0] state;
   logic [127:0] rk;
   logic [3:0]   rnd;
   logic [127:0] roundKey;
   logic [127:0] roundOut;
   logic [31:0]  a0, a1, a2, a3;
   logic [31:0]  b0, b1, b2, b3;

   // rk holds K(rnd+1); undo one key-expansion step to obtain K(rnd).
   always_comb begin
      {a0, a1, a2, a3} = rk;
      b3 = a3 ^ a2;
      b2 = a2 ^ a1;
      b1 = a1 ^ a0;
      b0 = a0 ^ subWord({b3[23:0], b3[31:24]}) ^ {RCON[rnd + 4'd1], 24'h0};
      roundKey = {b0, b1, b2, b3};
   end

   decryption_round u_round (
      .i_state    (state),
      .i_roundKey (roundKey),
      .i_lastRound(rnd == 4'd0),
      .o_state    (roundOut)
   );

   assign o_busy = ~o_ready;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         fsm         <= IDLE;
         state       <= '0;
         rk          <= '0;
         rnd         <= '0;
         o_ready     <= 1'b1;
         o_valid     <= 1'b0;
         o_plainText <= '0;
      end else begin
         o_valid <= 1'b0;
         case (fsm)
            IDLE: begin
               if (i_start) begin
                  state   <= i_cipherText ^ i_decKey;
                  rk      <= i_decKey;
                  rnd     <= 4'd9;
                  o_ready <= 1'b0;
                  fsm     <= ROUND;
               end
            end
            ROUND: begin
               state <= roundOut;
               rk    <= roundKey;
               if (rnd == 4'd0) begin
                  o_plainText <= roundOut;
                  o_valid     <= 1'b1;
                  o_ready     <= 1'b1;
                  fsm         <= IDLE;
               end else begin
                  rnd <= rnd - 4'd1;
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes128_decrypt_core.sv
// Self-checking bench for aes128_decrypt_core: FIPS-197 vectors, protocol corners
// and random blocks checked against a forward-cipher reference model.
module tb_aes128_decrypt_core;

   logic         i_clk = 1'b0;
   logic         i_rst;
   logic         i_start;
   logic [127:0] i_cipherText;
   logic [127:0] i_decKey;
   logic         o_ready;
   logic         o_busy;
   logic         o_valid;
   logic [127:0] o_plainText;

   aes128_decrypt_core dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_start     (i_start),
      .i_cipherText(i_cipherText),
      .i_decKey    (i_decKey),
      .o_ready     (o_ready),
      .o_busy      (o_busy),
      .o_valid     (o_valid),
      .o_plainText (o_plainText)
   );

   always #5 i_clk = ~i_clk;

   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
   localparam logic [127:0] Z_K10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   int passCount  = 0;
   int checkCount = 0;
   logic [7:0] sbox [256];

   task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
   endtask

   // ---------------- reference model: forward AES built from field arithmetic
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] d = {b, b};
      return d[15-n -: 8];
   endfunction

   task automatic buildSbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic modelEncrypt(input logic [127:0] pt, input logic [127:0] key0,
                               output logic [127:0] ct, output logic [127:0] k10);
      logic [31:0]  w [44];
      logic [31:0]  tmp;
      logic [7:0]   rc;
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   m [16];
      logic [127:0] blk;
      for (int i = 0; i < 4; i++) w[i] = key0[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
            rc  = xt(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      blk = pt ^ {w[0], w[1], w[2], w[3]};
      for (int rd = 1; rd <= 10; rd++) begin
         for (int i = 0; i < 16; i++) s[i] = sbox[blk[127-8*i -: 8]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               m[4*c+r] = (rd == 10) ? t[4*c+r]
                        : xt(t[4*c+r]) ^ gmul(t[4*c+(r+1)%4], 8'h03) ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
         for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = m[i];
         blk = blk ^ {w[4*rd], w[4*rd+1], w[4*rd+2], w[4*rd+3]};
      end
      ct  = blk;
      k10 = {w[40], w[41], w[42], w[43]};
   endtask

   // ---------------- stimulus helpers (drive and sample on the falling edge)
   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic cycle();
      @(posedge i_clk);
      @(negedge i_clk);
   endtask

   // Presents a block for one edge, then scrambles the inputs.
   task automatic startJob(input logic [127:0] ct, input logic [127:0] key);
      i_cipherText = ct;
      i_decKey     = key;
      i_start      = 1'b1;
      cycle();
      i_start      = 1'b0;
      i_cipherText = rand128();
      i_decKey     = rand128();
   endtask

   // Counts edges until o_valid is seen, bounded; also tracks busy/ready while waiting.
   task automatic waitValid(output int edges, output logic busyOk);
      edges  = 0;
      busyOk = 1'b1;
      while (!o_valid && edges < 30) begin
         busyOk = busyOk & o_busy & ~o_ready;
         cycle();
         edges++;
      end
   endtask

   task automatic runAndCheck(input string tag, input logic [127:0] ct, input logic [127:0] key,
                              input logic [127:0] expPt);
      int   edges;
      logic busyOk;
      startJob(ct, key);
      waitValid(edges, busyOk);
      check({tag, " latency"}, 128'(edges), 128'd10);
      check({tag, " busy"}, 128'(busyOk), 128'd1);
      check({tag, " valid"}, 128'(o_valid), 128'd1);
      check({tag, " ready"}, 128'(o_ready), 128'd1);
      check({tag, " plaintext"}, o_plainText, expPt);
      cycle();
      check({tag, " valid pulse"}, 128'(o_valid), 128'd0);
      check({tag, " hold"}, o_plainText, expPt);
   endtask

   initial begin
      int           edges;
      logic         busyOk;
      logic         sawValid;
      logic [127:0] pt, key0, ct, k10;

      i_rst        = 1'b1;
      i_start      = 1'b0;
      i_cipherText = '0;
      i_decKey     = '0;
      buildSbox();

      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      check("reset ready", 128'(o_ready), 128'd1);
      check("reset busy", 128'(o_busy), 128'd0);
      check("reset valid", 128'(o_valid), 128'd0);
      check("reset plaintext", o_plainText, 128'd0);
      i_rst = 1'b0;
      cycle();

      runAndCheck("c1", C1_CT, C1_K10, C1_PT);
      runAndCheck("appB", B_CT, B_K10, B_PT);

      // Zero-key block, then App. B started in the o_valid cycle.
      startJob(Z_CT, Z_K10);
      waitValid(edges, busyOk);
      check("zero latency", 128'(edges), 128'd10);
      check("zero plaintext", o_plainText, 128'd0);
      i_cipherText = B_CT;
      i_decKey     = B_K10;
      i_start      = 1'b1;
      cycle();
      i_start      = 1'b0;
      i_cipherText = rand128();
      check("b2b accepted", 128'(o_busy), 128'd1);
      waitValid(edges, busyOk);
      check("b2b spacing", 128'(edges + 1), 128'd11);
      check("b2b plaintext", o_plainText, B_PT);
      cycle();

      // Start pulse with new data at T+4 is ignored.
      startJob(C1_CT, C1_K10);
      repeat (3) cycle();
      i_cipherText = rand128();
      i_decKey     = rand128();
      i_start      = 1'b1;
      cycle();
      i_start      = 1'b0;
      waitValid(edges, busyOk);
      check("ignore latency", 128'(edges), 128'd6);
      check("ignore plaintext", o_plainText, C1_PT);
      cycle();

      // Reset at T+6 aborts the job.
      startJob(C1_CT, C1_K10);
      repeat (5) cycle();
      i_rst = 1'b1;
      cycle();
      check("abort ready", 128'(o_ready), 128'd1);
      check("abort busy", 128'(o_busy), 128'd0);
      check("abort plaintext", o_plainText, 128'd0);
      i_rst    = 1'b0;
      sawValid = 1'b0;
      for (int i = 0; i < 15; i++) begin
         sawValid = sawValid | o_valid;
         cycle();
      end
      check("abort no valid", 128'(sawValid), 128'd0);
      runAndCheck("restart", C1_CT, C1_K10, C1_PT);

      // Reset wins over a simultaneous start.
      i_rst        = 1'b1;
      i_start      = 1'b1;
      i_cipherText = C1_CT;
      i_decKey     = C1_K10;
      cycle();
      i_rst   = 1'b0;
      i_start = 1'b0;
      check("rst priority ready", 128'(o_ready), 128'd1);
      cycle();
      check("rst priority idle", 128'(o_busy), 128'd0);

      for (int n = 0; n < 6; n++) begin
         pt   = rand128();
         key0 = rand128();
         modelEncrypt(pt, key0, ct, k10);
         runAndCheck($sformatf("rand%0d", n), ct, k10, pt);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
